nabp_filtered_ram_swap_control: RTL
===================================

Name: nabp_filtered_ram_swap_control

Overview:
- Responder end of the filtered-RAM angle protocol. The processing swap control is the requester: it issues next-angle and release requests and reads filtered samples by s index.
- Owns two filtered-data banks. The filter stage fills one bank per angle while processing reads the others.
- Serves up to two concurrently active angles. The second active angle exists only during the diverged fill-and-shift phase.

Parameters:
- ANGLE_W, 9: angle index width (kAngleLength).
- DATA_W, 16: signed filtered sample width (kFilteredDataLength).
- S_W, 9: s index width (kSLength). Each bank holds 2**S_W words.
- NO_OF_ANGLES, 180: angles per frame.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- fl_we  in  1  filter write strobe.
- fl_s_val  in  S_W  write address.
- fl_val  in  DATA_W  write data.
- fl_angle  in  ANGLE_W  angle tag; sampled on the first write to a bank.
- fl_last  in  1  with fl_we: last sample of this angle.
- fl_ready  out  1  a bank is FILLING or EMPTY.
- fr_next_angle  in  1  requester wants the next angle (level).
- fr_next_angle_ack  out  1  single-cycle grant.
- fr_prev_angle_release  in  1  requester is done with its oldest angle (level).
- fr_prev_angle_release_ack  out  1  single-cycle grant.
- fr_angle  out  ANGLE_W  newest active angle.
- fr_has_next_angle  out  1  current frame still has unactivated angles.
- fr0_s_val, fr1_s_val  in  S_W  read addresses.
- fr0_val, fr1_val  out  DATA_W  read data.
- err_overflow  out  1  sticky: fl_we seen while fl_ready=0.

Behaviour:
- Bank states: EMPTY -> FILLING -> FULL -> ACTIVE -> EMPTY.
  - Activation order equals fill order. Keep a 1-bit oldest-full pointer and a 1-bit oldest-active pointer.
- Reset (asynchronous):
  - both banks EMPTY; fr_angle=0; frame count=0; fr_has_next_angle=1.
  - both acks=0; err_overflow=0; fl_ready=1; fr0_val=fr1_val=0.
  - Reset mid-operation discards all bank contents and tags.
- Fill side:
  - Target bank is the FILLING bank if one exists, else the EMPTY bank in ping-pong order.
  - First accepted write moves the bank to FILLING and latches fl_angle.
  - fl_we with fl_last moves it to FULL at that edge.
  - fl_we while fl_ready=0 is ignored and sets err_overflow.
- Release (Mealy ack, same cycle as request; release takes priority over next-angle):
  - Two ACTIVE banks (diverged): ack immediately and free the oldest active bank. fr_angle is unchanged.
  - At most one ACTIVE bank: ack only when a FULL bank exists. Free the active bank (if any) and activate the FULL bank. fr_angle takes its tag at the edge.
  - If the frame count had reached NO_OF_ANGLES, the count restarts at 1 (new frame). Otherwise it increments.
- Next angle (Mealy ack):
  - fr_next_angle_ack = fr_next_angle && FULL bank exists && exactly one ACTIVE && !fr_prev_angle_release.
  - On ack: activate the FULL bank, fr_angle <= its tag, frame count +1.
  - A request with no FULL bank waits with no ack. A bank turning FULL in cycle t can be acked from t+1.
- fr_has_next_angle = (frame count != NO_OF_ANGLES); registered.
- Commit rule: every grant commits state at the edge of its ack cycle. The requester must consume acks in the same cycle.
- Reads:
  - Synchronous, 1-cycle latency. Address in cycle t gives data in t+1.
  - One ACTIVE bank: both ports read it.
  - Two ACTIVE banks: fr0 reads the older angle, fr1 the newer. Routing is sampled with the address.
  - No ACTIVE bank: outputs hold their last value.
- Same-cycle fill completion and activation of the other bank is legal. The filling bank is never activated.

Decomposition:
- Shared package:
  - bank-state enum (EMPTY, FILLING, FULL, ACTIVE);
  - kAngleLength, kFilteredDataLength, kSLength, NO_OF_ANGLES.
- Sub-module nabp_filtered_ram_bank: 1 write port, 2 synchronous read ports. Instantiated twice.

Test Plan:
- Reset, fill angle 7 (512 writes, last at s=511), assert release → ack in the first cycle it is asserted after bank FULL. fr_angle=7 the next cycle. has_next=1.
- Angle 7 active, fill angle 8, assert next_angle → same-cycle ack. fr_angle=8. fr0 reads s=3 of angle 7, fr1 reads s=3 of angle 8 one cycle later.
- Diverged, assert release → immediate ack. Both ports return angle-8 data. Bank 0 EMPTY, fl_ready=1.
- next_angle asserted with nothing FULL → no ack for 20 cycles. Ack on the cycle after fl_last.
- Both banks non-EMPTY, extra fl_we → write ignored, err_overflow=1 and stays 1 until reset.
- Activate 180 angles → has_next=0 after the 180th ack. Next release with angle 0 FULL → ack, frame count 1, has_next=1. Async reset mid-fill → all outputs at reset values.

Source files
------------

// File: rtl/nabp_filtered_ram_swap_control_pkg.sv
// Shared types and default sizes for the filtered-RAM angle swap control.
package nabp_filtered_ram_swap_control_pkg;

  localparam int unsigned kAngleLength        = 9;
  localparam int unsigned kFilteredDataLength = 16;
  localparam int unsigned kSLength            = 9;
  localparam int unsigned NO_OF_ANGLES        = 180;

  typedef enum logic [1:0] {
    BankEmpty,
    BankFilling,
    BankFull,
    BankActive
  } bank_state_e;

endpackage

// File: rtl/nabp_filtered_ram_bank.sv
// One filtered-data bank: single write port, two synchronous read ports.
module nabp_filtered_ram_bank
  import nabp_filtered_ram_swap_control_pkg::*;
#(
  parameter int unsigned DATA_W = kFilteredDataLength,
  parameter int unsigned S_W    = kSLength
) (
  input  logic              clk,
  input  logic              we,
  input  logic [S_W-1:0]    waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [S_W-1:0]    raddr0,
  input  logic [S_W-1:0]    raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1
);

  logic [DATA_W-1:0] mem [2**S_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata0 <= mem[raddr0];
    rdata1 <= mem[raddr1];
  end

endmodule

// File: rtl/nabp_filtered_ram_swap_control.sv
// Responder side of the filtered-RAM angle protocol: two banks cycling through
// EMPTY -> FILLING -> FULL -> ACTIVE, activated in fill order.
module nabp_filtered_ram_swap_control #(
  parameter int unsigned ANGLE_W      = nabp_filtered_ram_swap_control_pkg::kAngleLength,
  parameter int unsigned DATA_W       = nabp_filtered_ram_swap_control_pkg::kFilteredDataLength,
  parameter int unsigned S_W          = nabp_filtered_ram_swap_control_pkg::kSLength,
  parameter int unsigned NO_OF_ANGLES = nabp_filtered_ram_swap_control_pkg::NO_OF_ANGLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fl_we,
  input  logic [S_W-1:0]     fl_s_val,
  input  logic [DATA_W-1:0]  fl_val,
  input  logic [ANGLE_W-1:0] fl_angle,
  input  logic               fl_last,
  output logic               fl_ready,
  input  logic               fr_next_angle,
  output logic               fr_next_angle_ack,
  input  logic               fr_prev_angle_release,
  output logic               fr_prev_angle_release_ack,
  output logic [ANGLE_W-1:0] fr_angle,
  output logic               fr_has_next_angle,
  input  logic [S_W-1:0]     fr0_s_val,
  input  logic [S_W-1:0]     fr1_s_val,
  output logic [DATA_W-1:0]  fr0_val,
  output logic [DATA_W-1:0]  fr1_val,
  output logic               err_overflow
);

  import nabp_filtered_ram_swap_control_pkg::*;

  localparam int unsigned CntW = $clog2(NO_OF_ANGLES + 1);

  bank_state_e        st_q [2];
  bank_state_e        st_d [2];
  logic [ANGLE_W-1:0] tag_q [2];
  logic [ANGLE_W-1:0] tag_d [2];
  logic               fill_ptr_q, fill_ptr_d;
  logic               full_ptr_q, full_ptr_d;
  logic               act_ptr_q, act_ptr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic               has_next_q, err_q, err_d;
  logic               rd_vld_q, rd_sel0_q, rd_sel1_q;
  logic [DATA_W-1:0]  hold0_q, hold1_q;
  logic [DATA_W-1:0]  rd0 [2];
  logic [DATA_W-1:0]  rd1 [2];

  logic [1:0] is_empty, is_fill, is_full, is_act;
  logic       two_act, one_act, full_any, full_sel, act_sel, fill_tgt, wr_ok;
  logic       rel_ack, next_ack;

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      is_empty[b] = (st_q[b] == BankEmpty);
      is_fill[b]  = (st_q[b] == BankFilling);
      is_full[b]  = (st_q[b] == BankFull);
      is_act[b]   = (st_q[b] == BankActive);
    end
  end

  // With a single FULL/ACTIVE bank the pointer is implied; it only breaks ties.
  assign two_act   = &is_act;
  assign one_act   = ^is_act;
  assign full_any  = |is_full;
  assign full_sel  = (&is_full) ? full_ptr_q : is_full[1];
  assign act_sel   = two_act ? act_ptr_q : is_act[1];
  assign fill_tgt  = (|is_fill) ? is_fill[1] : (is_empty[fill_ptr_q] ? fill_ptr_q : ~fill_ptr_q);
  assign fl_ready  = |(is_fill | is_empty);
  assign wr_ok     = fl_we && fl_ready;
  assign rel_ack   = fr_prev_angle_release && (two_act || full_any);
  assign next_ack  = fr_next_angle && full_any && one_act && !fr_prev_angle_release;

  assign fr_prev_angle_release_ack = rel_ack;
  assign fr_next_angle_ack         = next_ack;
  assign fr_angle                  = angle_q;
  assign fr_has_next_angle         = has_next_q;
  assign err_overflow              = err_q;

  always_comb begin
    st_d       = st_q;
    tag_d      = tag_q;
    fill_ptr_d = fill_ptr_q;
    cnt_d      = cnt_q;
    angle_d    = angle_q;
    err_d      = err_q | (fl_we & ~fl_ready);
    full_ptr_d = full_ptr_q;
    act_ptr_d  = act_ptr_q;
    if (rel_ack && two_act) begin
      st_d[act_sel] = BankEmpty;
    end else if (rel_ack || next_ack) begin
      if (rel_ack && one_act) begin
        st_d[act_sel] = BankEmpty;
      end
      st_d[full_sel] = BankActive;
      angle_d        = tag_q[full_sel];
      cnt_d          = (cnt_q == CntW'(NO_OF_ANGLES)) ? CntW'(1) : cnt_q + 1'b1;
    end
    // Fill only touches EMPTY/FILLING banks, so it never collides with the above.
    if (wr_ok) begin
      if (is_empty[fill_tgt]) begin
        st_d[fill_tgt]  = BankFilling;
        tag_d[fill_tgt] = fl_angle;
      end
      if (fl_last) begin
        st_d[fill_tgt] = BankFull;
        fill_ptr_d     = ~fill_tgt;
      end
    end
    if ((st_d[0] == BankFull) != (st_d[1] == BankFull)) begin
      full_ptr_d = (st_d[1] == BankFull);
    end
    if ((st_d[0] == BankActive) != (st_d[1] == BankActive)) begin
      act_ptr_d = (st_d[1] == BankActive);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q       <= '{BankEmpty, BankEmpty};
      tag_q      <= '{default: '0};
      fill_ptr_q <= 1'b0;
      full_ptr_q <= 1'b0;
      act_ptr_q  <= 1'b0;
      cnt_q      <= '0;
      angle_q    <= '0;
      has_next_q <= 1'b1;
      err_q      <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_sel0_q  <= 1'b0;
      rd_sel1_q  <= 1'b0;
      hold0_q    <= '0;
      hold1_q    <= '0;
    end else begin
      st_q       <= st_d;
      tag_q      <= tag_d;
      fill_ptr_q <= fill_ptr_d;
      full_ptr_q <= full_ptr_d;
      act_ptr_q  <= act_ptr_d;
      cnt_q      <= cnt_d;
      angle_q    <= angle_d;
      has_next_q <= (cnt_d != CntW'(NO_OF_ANGLES));
      err_q      <= err_d;
      rd_vld_q   <= |is_act;
      rd_sel0_q  <= act_sel;
      rd_sel1_q  <= two_act ? ~act_ptr_q : act_sel;
      hold0_q    <= fr0_val;
      hold1_q    <= fr1_val;
    end
  end

  assign fr0_val = rd_vld_q ? rd0[rd_sel0_q] : hold0_q;
  assign fr1_val = rd_vld_q ? rd1[rd_sel1_q] : hold1_q;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    nabp_filtered_ram_bank #(
      .DATA_W (DATA_W),
      .S_W    (S_W)
    ) u_bank (
      .clk    (clk),
      .we     (wr_ok && (fill_tgt == 1'(b))),
      .waddr  (fl_s_val),
      .wdata  (fl_val),
      .raddr0 (fr0_s_val),
      .raddr1 (fr1_s_val),
      .rdata0 (rd0[b]),
      .rdata1 (rd1[b])
    );
  end

endmodule
